// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259A-compatible PIC priority/in-service slice.
package pic_pkg;

  localparam int NUM_IR = 8;
  localparam int LEVEL_W = 3;
  localparam logic [LEVEL_W-1:0] SPURIOUS_LEVEL = 3'd7;

  typedef enum logic {
    IDLE,
    ACK2
  } pic_state_t;

  typedef enum logic [2:0] {
    EOI_NONSPEC     = 3'b000,
    EOI_SPEC        = 3'b001,
    EOI_ROT_NONSPEC = 3'b010,
    EOI_ROT_SPEC    = 3'b011,
    EOI_SET_PRIO    = 3'b100
  } eoi_op_t;

  function automatic logic [NUM_IR-1:0] level_onehot(input logic [LEVEL_W-1:0] lvl);
    return NUM_IR'(1) << lvl;
  endfunction

  // Rank 0 is the highest priority, which sits just above priority_base.
  function automatic logic [LEVEL_W-1:0] prio_rank(input logic [LEVEL_W-1:0] lvl,
                                                   input logic [LEVEL_W-1:0] base);
    return lvl - base - 3'd1;
  endfunction

endpackage

// File: rtl/pic_priority_isr_if.sv
// Request/mask/acknowledge/EOI bundle between the PIC control and request stages and the priority block.
interface pic_priority_isr_if;
  import pic_pkg::*;

  logic [NUM_IR-1:0]  irr_priority;
  logic [NUM_IR-1:0]  imr;
  logic               aeoi;
  logic               rotate_aeoi;
  logic               inta_strobe;
  logic               eoi_valid;
  logic [2:0]         eoi_op;
  logic [LEVEL_W-1:0] eoi_level;
  logic               int_req;
  logic               inta_freeze;
  logic [NUM_IR-1:0]  inta_1;
  logic [NUM_IR-1:0]  isr;
  logic               vector_valid;
  logic [LEVEL_W-1:0] vector_level;

  modport master (
    output irr_priority, imr, aeoi, rotate_aeoi, inta_strobe, eoi_valid, eoi_op, eoi_level,
    input  int_req, inta_freeze, inta_1, isr, vector_valid, vector_level
  );

  modport slave (
    input  irr_priority, imr, aeoi, rotate_aeoi, inta_strobe, eoi_valid, eoi_op, eoi_level,
    output int_req, inta_freeze, inta_1, isr, vector_valid, vector_level
  );

endinterface

// File: rtl/pic_rot_prio_enc.sv
// Rotating priority encoder: finds the highest-priority set bit, where (base+1) mod 8 ranks first.
module pic_rot_prio_enc
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0]  vec,
  input  logic [LEVEL_W-1:0] base,
  output logic               found,
  output logic [LEVEL_W-1:0] level
);

  // Walk from the lowest-priority position upward so the highest-priority hit wins last.
  always_comb begin
    found = 1'b0;
    level = '0;
    for (int i = NUM_IR; i >= 1; i--) begin
      if (vec[base + LEVEL_W'(i)]) begin
        found = 1'b1;
        level = base + LEVEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/pic_priority_isr.sv
// Priority resolver, in-service register and two-pulse INTA sequencer of the 8259A-compatible PIC.
module pic_priority_isr
  import pic_pkg::*;
#(
  parameter int                 NUM_IR         = pic_pkg::NUM_IR,
  parameter logic [LEVEL_W-1:0] SPURIOUS_LEVEL = pic_pkg::SPURIOUS_LEVEL
) (
  input  logic               clk,
  input  logic               reset,
  pic_priority_isr_if.slave  bus
);

  pic_state_t         state;
  logic [NUM_IR-1:0]  isr_q;
  logic [NUM_IR-1:0]  inta_1_q;
  logic [LEVEL_W-1:0] priority_base;
  logic [LEVEL_W-1:0] level_q;
  logic [LEVEL_W-1:0] vector_level_q;
  logic               spurious_q;
  logic               int_req_q;
  logic               inta_freeze_q;
  logic               vector_valid_q;

  logic [NUM_IR-1:0]  req_eff;
  logic               cand_found;
  logic [LEVEL_W-1:0] cand_level;
  logic               isr_found;
  logic [LEVEL_W-1:0] isr_level;
  logic               int_req_next;

  logic [NUM_IR-1:0]  eoi_clear;
  logic               eoi_rotate;
  logic [LEVEL_W-1:0] eoi_base;
  logic [NUM_IR-1:0]  ack_set;
  logic [NUM_IR-1:0]  aeoi_clear;
  logic               aeoi_rotate;

  assign req_eff = bus.irr_priority & ~bus.imr;

  pic_rot_prio_enc u_req_enc (
    .vec   (req_eff),
    .base  (priority_base),
    .found (cand_found),
    .level (cand_level)
  );

  pic_rot_prio_enc u_isr_enc (
    .vec   (isr_q),
    .base  (priority_base),
    .found (isr_found),
    .level (isr_level)
  );

  assign int_req_next = cand_found &&
                        (!isr_found || (prio_rank(cand_level, priority_base) <
                                        prio_rank(isr_level, priority_base)));

  // OCW2 decode: which ISR bit to drop and where the priority base moves.
  always_comb begin
    eoi_clear  = '0;
    eoi_rotate = 1'b0;
    eoi_base   = priority_base;
    if (bus.eoi_valid) begin
      case (eoi_op_t'(bus.eoi_op))
        EOI_NONSPEC, EOI_ROT_NONSPEC: begin
          if (isr_found) begin
            eoi_clear  = level_onehot(isr_level);
            eoi_rotate = (eoi_op_t'(bus.eoi_op) == EOI_ROT_NONSPEC);
            eoi_base   = isr_level;
          end
        end
        EOI_SPEC, EOI_ROT_SPEC: begin
          eoi_clear  = level_onehot(bus.eoi_level);
          eoi_rotate = (eoi_op_t'(bus.eoi_op) == EOI_ROT_SPEC);
          eoi_base   = bus.eoi_level;
        end
        EOI_SET_PRIO: begin
          eoi_rotate = 1'b1;
          eoi_base   = bus.eoi_level;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ack_set     = '0;
    aeoi_clear  = '0;
    aeoi_rotate = 1'b0;
    if (bus.inta_strobe) begin
      if (state == IDLE) begin
        if (cand_found) ack_set = level_onehot(cand_level);
      end else if (bus.aeoi && !spurious_q) begin
        aeoi_clear  = level_onehot(level_q);
        aeoi_rotate = bus.rotate_aeoi;
      end
    end
  end

  // An explicit OCW2 rotation/set-priority wins over an AEOI rotation in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      isr_q          <= '0;
      inta_1_q       <= '0;
      priority_base  <= 3'd7;
      level_q        <= '0;
      vector_level_q <= '0;
      spurious_q     <= 1'b0;
      int_req_q      <= 1'b0;
      inta_freeze_q  <= 1'b0;
      vector_valid_q <= 1'b0;
    end else begin
      inta_1_q       <= '0;
      vector_valid_q <= 1'b0;
      int_req_q      <= int_req_next;
      isr_q          <= (isr_q & ~(eoi_clear | aeoi_clear)) | ack_set;
      if (eoi_rotate)       priority_base <= eoi_base;
      else if (aeoi_rotate) priority_base <= level_q;
      case (state)
        IDLE: begin
          if (bus.inta_strobe) begin
            state         <= ACK2;
            inta_freeze_q <= 1'b1;
            int_req_q     <= 1'b0;
            inta_1_q      <= ack_set;
            level_q       <= cand_found ? cand_level : SPURIOUS_LEVEL;
            spurious_q    <= !cand_found;
          end
        end
        ACK2: begin
          if (bus.inta_strobe) begin
            state          <= IDLE;
            inta_freeze_q  <= 1'b0;
            vector_valid_q <= 1'b1;
            vector_level_q <= level_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.int_req      = int_req_q;
  assign bus.inta_freeze  = inta_freeze_q;
  assign bus.inta_1       = inta_1_q;
  assign bus.isr          = isr_q;
  assign bus.vector_valid = vector_valid_q;
  assign bus.vector_level = vector_level_q;

endmodule

// File: tb/tb_pic_priority_isr.sv
// Table-driven bench for pic_priority_isr: each step's hand-derived expectation is queued, then popped after the clock edge.
module tb_pic_priority_isr;
  import pic_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pic_priority_isr_if bus ();

  pic_priority_isr dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] irr;
    logic [7:0] imr;
    logic       aeoi;
    logic       rot;
    logic       strobe;
    logic       ev;
    logic [2:0] eop;
    logic [2:0] elev;
    logic       int_req;
    logic       freeze;
    logic [7:0] inta_1;
    logic [7:0] isr;
    logic       vv;
    logic [2:0] vl;
  } vec_t;

  typedef struct {
    logic       int_req;
    logic       freeze;
    logic [7:0] inta_1;
    logic [7:0] isr;
    logic       vv;
    logic [2:0] vl;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic void add(input logic [7:0] irr, input logic [7:0] imr,
                              input logic aeoi, input logic rot, input logic strobe,
                              input logic ev, input logic [2:0] eop, input logic [2:0] elev,
                              input logic int_req, input logic freeze,
                              input logic [7:0] inta_1, input logic [7:0] isr,
                              input logic vv, input logic [2:0] vl);
    vec_t v;
    v.irr = irr; v.imr = imr; v.aeoi = aeoi; v.rot = rot; v.strobe = strobe;
    v.ev = ev; v.eop = eop; v.elev = elev;
    v.int_req = int_req; v.freeze = freeze; v.inta_1 = inta_1; v.isr = isr;
    v.vv = vv; v.vl = vl;
    vecs.push_back(v);
  endfunction

  task automatic checkVal(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s step %0d: got 0x%02h, expected 0x%02h", name, idx, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    bus.irr_priority = v.irr;
    bus.imr          = v.imr;
    bus.aeoi         = v.aeoi;
    bus.rotate_aeoi  = v.rot;
    bus.inta_strobe  = v.strobe;
    bus.eoi_valid    = v.ev;
    bus.eoi_op       = v.eop;
    bus.eoi_level    = v.elev;
    e.int_req = v.int_req; e.freeze = v.freeze; e.inta_1 = v.inta_1;
    e.isr = v.isr; e.vv = v.vv; e.vl = v.vl;
    sb_q.push_back(e);
  endtask

  task automatic checkOutput(input int idx);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL scoreboard step %0d: got empty queue, expected an entry", idx);
    end else begin
      e = sb_q.pop_front();
      checkVal("int_req",      idx, 8'(bus.int_req),      8'(e.int_req));
      checkVal("inta_freeze",  idx, 8'(bus.inta_freeze),  8'(e.freeze));
      checkVal("inta_1",       idx, bus.inta_1,           e.inta_1);
      checkVal("isr",          idx, bus.isr,              e.isr);
      checkVal("vector_valid", idx, 8'(bus.vector_valid), 8'(e.vv));
      checkVal("vector_level", idx, 8'(bus.vector_level), 8'(e.vl));
    end
  endtask

  task automatic checkAllZero(input int idx);
    checkVal("rst_int_req",      idx, 8'(bus.int_req),      8'h00);
    checkVal("rst_inta_freeze",  idx, 8'(bus.inta_freeze),  8'h00);
    checkVal("rst_inta_1",       idx, bus.inta_1,           8'h00);
    checkVal("rst_isr",          idx, bus.isr,              8'h00);
    checkVal("rst_vector_valid", idx, 8'(bus.vector_valid), 8'h00);
    checkVal("rst_vector_level", idx, 8'(bus.vector_level), 8'h00);
  endtask

  task automatic idleInputs();
    bus.irr_priority = 8'h00;
    bus.imr          = 8'h00;
    bus.aeoi         = 1'b0;
    bus.rotate_aeoi  = 1'b0;
    bus.inta_strobe  = 1'b0;
    bus.eoi_valid    = 1'b0;
    bus.eoi_op       = 3'd0;
    bus.eoi_level    = 3'd0;
  endtask

  initial begin
    // irr imr aeoi rot strobe ev eop elev | int_req freeze inta_1 isr vv vl
    add(8'h0C, 8'h00, 0, 0, 0, 0, 3'd0, 3'd0, 1, 0, 8'h00, 8'h00, 0, 3'd0);
    add(8'h0C, 8'h00, 0, 0, 1, 0, 3'd0, 3'd0, 0, 1, 8'h04, 8'h04, 0, 3'd0);
    add(8'h08, 8'h00, 0, 0, 0, 0, 3'd0, 3'd0, 0, 1, 8'h00, 8'h04, 0, 3'd0);
    add(8'h08, 8'h00, 0, 0, 1, 0, 3'd0, 3'd0, 0, 0, 8'h00, 8'h04, 1, 3'd2);
    add(8'h01, 8'h00, 0, 0, 0, 0, 3'd0, 3'd0, 1, 0, 8'h00, 8'h04, 0, 3'd2);
    add(8'h08, 8'h00, 0, 0, 0, 0, 3'd0, 3'd0, 0, 0, 8'h00, 8'h04, 0, 3'd2);
    add(8'h00, 8'h00, 0, 0, 0, 1, 3'd0, 3'd0, 0, 0, 8'h00, 8'h00, 0, 3'd2);
    add(8'h10, 8'hFF, 0, 0, 1, 0, 3'd0, 3'd0, 0, 1, 8'h00, 8'h00, 0, 3'd2);
    add(8'h10, 8'hFF, 0, 0, 1, 0, 3'd0, 3'd0, 0, 0, 8'h00, 8'h00, 1, 3'd7);
    add(8'h08, 8'h00, 1, 1, 0, 0, 3'd0, 3'd0, 1, 0, 8'h00, 8'h00, 0, 3'd7);
    add(8'h08, 8'h00, 1, 1, 1, 0, 3'd0, 3'd0, 0, 1, 8'h08, 8'h08, 0, 3'd7);
    add(8'h00, 8'h00, 1, 1, 1, 0, 3'd0, 3'd0, 0, 0, 8'h00, 8'h00, 1, 3'd3);
    add(8'h11, 8'h00, 1, 1, 0, 0, 3'd0, 3'd0, 1, 0, 8'h00, 8'h00, 0, 3'd3);
    add(8'h11, 8'h00, 1, 1, 1, 0, 3'd0, 3'd0, 0, 1, 8'h10, 8'h10, 0, 3'd3);
    add(8'h01, 8'h00, 1, 1, 1, 0, 3'd0, 3'd0, 0, 0, 8'h00, 8'h00, 1, 3'd4);
    add(8'h00, 8'h00, 0, 0, 0, 1, 3'd4, 3'd7, 0, 0, 8'h00, 8'h00, 0, 3'd4);
    add(8'h08, 8'h00, 0, 0, 0, 0, 3'd0, 3'd0, 1, 0, 8'h00, 8'h00, 0, 3'd4);
    add(8'h08, 8'h00, 0, 0, 1, 0, 3'd0, 3'd0, 0, 1, 8'h08, 8'h08, 0, 3'd4);
    add(8'h00, 8'h00, 0, 0, 1, 0, 3'd0, 3'd0, 0, 0, 8'h00, 8'h08, 1, 3'd3);
    add(8'h02, 8'h00, 0, 0, 0, 0, 3'd0, 3'd0, 1, 0, 8'h00, 8'h08, 0, 3'd3);
    add(8'h02, 8'h00, 0, 0, 1, 0, 3'd0, 3'd0, 0, 1, 8'h02, 8'h0A, 0, 3'd3);
    add(8'h00, 8'h00, 0, 0, 1, 0, 3'd0, 3'd0, 0, 0, 8'h00, 8'h0A, 1, 3'd1);
    add(8'h00, 8'h00, 0, 0, 0, 1, 3'd0, 3'd0, 0, 0, 8'h00, 8'h08, 0, 3'd1);
    add(8'h00, 8'h00, 0, 0, 0, 1, 3'd1, 3'd3, 0, 0, 8'h00, 8'h00, 0, 3'd1);
    add(8'h00, 8'h00, 0, 0, 0, 1, 3'd4, 3'd5, 0, 0, 8'h00, 8'h00, 0, 3'd1);
    add(8'h81, 8'h00, 0, 0, 0, 0, 3'd0, 3'd0, 1, 0, 8'h00, 8'h00, 0, 3'd1);
    add(8'h81, 8'h00, 0, 0, 1, 0, 3'd0, 3'd0, 0, 1, 8'h80, 8'h80, 0, 3'd1);
    add(8'h01, 8'h00, 0, 0, 1, 0, 3'd0, 3'd0, 0, 0, 8'h00, 8'h80, 1, 3'd7);
    add(8'h01, 8'h00, 0, 0, 0, 0, 3'd0, 3'd0, 0, 0, 8'h00, 8'h80, 0, 3'd7);
    add(8'h01, 8'h00, 0, 0, 0, 1, 3'd0, 3'd0, 0, 0, 8'h00, 8'h00, 0, 3'd7);
    add(8'h01, 8'h00, 0, 0, 0, 0, 3'd0, 3'd0, 1, 0, 8'h00, 8'h00, 0, 3'd7);
    add(8'h01, 8'h00, 0, 0, 1, 0, 3'd0, 3'd0, 0, 1, 8'h01, 8'h01, 0, 3'd7);
    add(8'h00, 8'h00, 0, 0, 1, 0, 3'd0, 3'd0, 0, 0, 8'h00, 8'h01, 1, 3'd0);
    add(8'h04, 8'h00, 0, 0, 1, 0, 3'd0, 3'd0, 0, 1, 8'h04, 8'h05, 0, 3'd0);
    add(8'h00, 8'h00, 1, 0, 1, 1, 3'd1, 3'd0, 0, 0, 8'h00, 8'h00, 1, 3'd2);
    add(8'h02, 8'h00, 0, 0, 0, 0, 3'd0, 3'd0, 1, 0, 8'h00, 8'h00, 0, 3'd2);
    add(8'h02, 8'h00, 0, 0, 1, 0, 3'd0, 3'd0, 0, 1, 8'h02, 8'h02, 0, 3'd2);
    add(8'h00, 8'h00, 0, 0, 1, 0, 3'd0, 3'd0, 0, 0, 8'h00, 8'h02, 1, 3'd1);
    add(8'h08, 8'h00, 0, 0, 1, 1, 3'd0, 3'd0, 0, 1, 8'h08, 8'h08, 0, 3'd1);
    add(8'h00, 8'h00, 0, 0, 1, 0, 3'd0, 3'd0, 0, 0, 8'h00, 8'h08, 1, 3'd3);
    add(8'h00, 8'h00, 0, 0, 0, 1, 3'd3, 3'd3, 0, 0, 8'h00, 8'h00, 0, 3'd3);
    add(8'h11, 8'h00, 0, 0, 0, 0, 3'd0, 3'd0, 1, 0, 8'h00, 8'h00, 0, 3'd3);
    add(8'h11, 8'h00, 0, 0, 1, 0, 3'd0, 3'd0, 0, 1, 8'h10, 8'h10, 0, 3'd3);
    add(8'h01, 8'h00, 0, 0, 1, 0, 3'd0, 3'd0, 0, 0, 8'h00, 8'h10, 1, 3'd4);
    add(8'h01, 8'h00, 0, 0, 0, 1, 3'd2, 3'd0, 0, 0, 8'h00, 8'h00, 0, 3'd4);
    add(8'h01, 8'h00, 0, 0, 0, 0, 3'd0, 3'd0, 1, 0, 8'h00, 8'h00, 0, 3'd4);
    add(8'h00, 8'h00, 0, 0, 0, 1, 3'd4, 3'd7, 0, 0, 8'h00, 8'h00, 0, 3'd4);
    add(8'h0C, 8'h00, 0, 0, 0, 0, 3'd0, 3'd0, 1, 0, 8'h00, 8'h00, 0, 3'd4);
    add(8'h0C, 8'h00, 0, 0, 1, 0, 3'd0, 3'd0, 0, 1, 8'h04, 8'h04, 0, 3'd4);

    reset = 1'b1;
    idleInputs();
    repeat (2) @(posedge clk);
    #1;
    checkAllZero(-1);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkOutput(i);
    end

    // Reset lands between the two INTA pulses; the acknowledge must be abandoned.
    #2;
    reset = 1'b1;
    #1;
    checkAllZero(100);
    idleInputs();
    @(negedge clk);
    reset = 1'b0;
    bus.inta_strobe = 1'b1;
    @(posedge clk);
    #1;
    checkVal("post_rst_freeze", 101, 8'(bus.inta_freeze),  8'h01);
    checkVal("post_rst_vv",     101, 8'(bus.vector_valid), 8'h00);
    checkVal("post_rst_inta_1", 101, bus.inta_1,           8'h00);
    @(posedge clk);
    #1;
    checkVal("post_rst_vv2",    102, 8'(bus.vector_valid), 8'h01);
    checkVal("post_rst_level",  102, 8'(bus.vector_level), 8'h07);
    checkVal("post_rst_isr",    102, bus.isr,              8'h00);
    bus.inta_strobe = 1'b0;
    @(posedge clk);
    #1;
    checkVal("post_rst_idle_vv", 103, 8'(bus.vector_valid), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pic_priority_isr.md
Name: pic_priority_isr

Overview:
- Downstream neighbour of the interrupt request register stage in the 8259A-compatible PIC.
- Consumes the latched request vector and the interrupt mask, then resolves the highest-priority unmasked request against the in-service register (ISR).
- Drives INT toward the CPU and sequences the two-pulse INTA acknowledge. During the acknowledge it freezes the request stage, sets the ISR bit and returns a one-hot clear vector to the request stage.
- Handles EOI/AEOI and rotating priority.

Parameters:
- NUM_IR, 8, number of interrupt levels; only 8 is supported.
- SPURIOUS_LEVEL, 7, level reported when the first INTA finds no valid request.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- irr_priority  in  8  latched requests from the request stage
- imr  in  8  interrupt mask; 1 = masked
- aeoi  in  1  automatic EOI mode, from control
- rotate_aeoi  in  1  rotate on automatic EOI
- inta_strobe  in  1  one-cycle pulse per CPU INTA pulse, from control
- eoi_valid  in  1  one-cycle OCW2 command strobe
- eoi_op  in  3  000 non-specific EOI, 001 specific EOI, 010 rotate-on-non-specific EOI, 011 rotate-on-specific EOI, 100 set priority; others = no-op
- eoi_level  in  3  level operand for specific/set-priority ops
- int_req  out  1  INT to CPU
- inta_freeze  out  1  freeze request-stage sampling
- inta_1  out  8  one-hot clear to request stage, one-cycle pulse
- isr  out  8  in-service register
- vector_valid  out  1  one-cycle pulse; vector_level is valid
- vector_level  out  3  acknowledged level for vector formation

Behaviour:
- Reset (async): state IDLE; isr=0, int_req=0, inta_freeze=0, inta_1=0, vector_valid=0, vector_level=0, priority_base=7 (IR0 highest).
- Priority order is rotational: the highest level is (priority_base+1) mod 8, descending with wrap-around.
- req_eff = irr_priority & ~imr.
- Candidate = highest-priority bit of req_eff.
- int_req is registered and is set when the candidate exists and outranks the highest ISR bit, or when ISR=0. Latency is 1 cycle from an input change. int_req is cleared on the first strobe.
- FSM states:
  - IDLE:
    - inta_strobe -> ACK2, with inta_freeze=1 registered.
    - If a candidate exists: set isr[cand], latch level=cand, inta_1=onehot(cand) for 1 cycle.
    - If no candidate: latch level=SPURIOUS_LEVEL; no ISR bit is set and inta_1=0.
  - ACK2:
    - inta_strobe -> IDLE; vector_valid=1 for 1 cycle with vector_level=latched level; inta_freeze=0.
    - If aeoi and not spurious: clear isr[level]. If rotate_aeoi is also set: priority_base=level.
  - inta_strobe in ACK2 only completes the sequence; it never starts a new one.
- Candidate selection happens only on the first strobe. Changes to irr_priority or imr while in ACK2 do not alter the latched level.
- EOI (accepted in any state, effective next cycle):
  - Non-specific: clear the highest-priority set ISR bit; no-op if ISR=0.
  - Specific: clear isr[eoi_level].
  - Rotate forms: clear as above, then priority_base = the cleared level (non-specific with ISR=0: no rotation).
  - Set priority: priority_base=eoi_level; ISR unchanged.
- Simultaneous EOI and second-strobe AEOI clear in the same cycle: both clears apply (bitwise OR).
- Simultaneous EOI and first strobe: the first strobe's ISR set is applied after the EOI clear. The candidate is compared against the pre-EOI ISR.
- Multiple ISR bits may be set (nesting); ISR bits never set spontaneously.
- Reset asserted mid-acknowledge aborts to IDLE. No vector_valid or inta_1 pulse is produced.

Decomposition:
- Shared package pic_pkg:
  - NUM_IR, LEVEL_W=3
  - FSM state typedef {IDLE, ACK2}
  - eoi_op encodings
  - SPURIOUS_LEVEL default
- One combinational sub-module, pic_rot_prio_enc. Inputs: 8-bit vector and priority_base. Outputs: found flag and 3-bit highest-priority level.
- The sub-module is instantiated twice: once for req_eff and once for the ISR.

Test Plan:
- Reset, irr_priority=0x0C, imr=0 -> int_req=1 next cycle; first strobe -> isr=0x04, inta_1=0x04 one cycle, inta_freeze=1; second strobe -> vector_valid with level=2, inta_freeze=0.
- isr=0x04 in service, irr_priority=0x01 -> int_req=1 (level 0 nests). Same with irr_priority=0x08 -> int_req stays 0.
- No request with imr=0xFF, first and second strobes -> level=7, isr unchanged 0, inta_1=0.
- aeoi=1, rotate_aeoi=1, service IR3 -> isr returns 0 after second strobe. priority_base=3, so IR4 now outranks IR0: irr_priority=0x11 acknowledges level 4.
- isr=0x0A, non-specific EOI -> isr=0x08. Specific EOI level 3 -> isr=0x00. Set priority level 5, irr_priority=0x81 -> acknowledges 7 before 0.
- Reset pulse between the first and second strobe -> all outputs 0, state IDLE, no vector_valid.
